// File: rtl/mic1_mem_if.sv
// MIC-1 initiator-side memory interface: sequences rd/wr/fetch strobes into timed memory
// transactions and captures read data into MDR/MBR. Define MIC1_MEMIF_FETCH_EN to build the fetch path.
module mic1_mem_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 9,
    parameter int RD_LAT = 1    // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mar,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] mdr_in,
    input  logic              rd,
    input  logic              wr,
    input  logic              fetch,
    output logic              busy,
    output logic [DATA_W-1:0] mdr_out,
    output logic              mdr_valid,
    output logic [DATA_W-1:0] mbr_out,
    output logic              mbr_valid,
    output logic              err,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [2:0] {
        IDLE, WRITE, RD_ISSUE, RD_WAIT
`ifdef MIC1_MEMIF_FETCH_EN
        , FE_ISSUE, FE_WAIT
`endif
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              done, acc_wr, acc_rd, err_req, cap_rd;
    logic              busy_q, busy_d, wen_q, wen_d, ren_q, ren_d, err_q, err_d;
    logic              mdr_valid_q, mdr_valid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, mdr_q, mdr_d;

`ifdef MIC1_MEMIF_FETCH_EN
    logic              pend_q, pend_d, fe_start, cap_fe;
    logic              mbr_valid_q, mbr_valid_d;
    logic [ADDR_W-1:0] pc_lat_q, pc_lat_d, fe_addr;
    logic [DATA_W-1:0] mbr_q, mbr_d;
`else
    logic unused_fetch;
    assign unused_fetch = ^{fetch, pc};
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            err_q       <= 1'b0;
            mdr_valid_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            mdr_q       <= '0;
`ifdef MIC1_MEMIF_FETCH_EN
            pend_q      <= 1'b0;
            pc_lat_q    <= '0;
            mbr_valid_q <= 1'b0;
            mbr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            err_q       <= err_d;
            mdr_valid_q <= mdr_valid_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            mdr_q       <= mdr_d;
`ifdef MIC1_MEMIF_FETCH_EN
            pend_q      <= pend_d;
            pc_lat_q    <= pc_lat_d;
            mbr_valid_q <= mbr_valid_d;
            mbr_q       <= mbr_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        acc_wr  = 1'b0;
        acc_rd  = 1'b0;
        err_req = 1'b0;
        cap_rd  = 1'b0;
`ifdef MIC1_MEMIF_FETCH_EN
        pend_d   = pend_q;
        pc_lat_d = pc_lat_q;
        fe_start = 1'b0;
        cap_fe   = 1'b0;
        fe_addr  = pc_lat_q;
`endif
        unique case (state_q)
            IDLE:     done = 1'b1;
            WRITE:    done = 1'b1;
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d   = LAT_LOAD;
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    cap_rd = 1'b1;
                    done   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
`ifdef MIC1_MEMIF_FETCH_EN
            FE_ISSUE: begin
                state_d = FE_WAIT;
                cnt_d   = LAT_LOAD;
            end
            FE_WAIT: begin
                if (cnt_q == 2'd0) begin
                    cap_fe = 1'b1;
                    done   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
`endif
            default:  state_d = IDLE;
        endcase
`ifdef MIC1_MEMIF_FETCH_EN
        // A fetch queued behind a write or read starts immediately, keeping busy high.
        if (done && pend_q) begin
            done     = 1'b0;
            pend_d   = 1'b0;
            state_d  = FE_ISSUE;
            fe_start = 1'b1;
        end
`endif
        if (done) begin
            state_d = IDLE;
            if (wr) begin
                state_d = WRITE;
                acc_wr  = 1'b1;
                err_req = rd;
`ifdef MIC1_MEMIF_FETCH_EN
                pend_d   = fetch;
                pc_lat_d = pc;
`endif
            end else if (rd) begin
                state_d = RD_ISSUE;
                acc_rd  = 1'b1;
`ifdef MIC1_MEMIF_FETCH_EN
                pend_d   = fetch;
                pc_lat_d = pc;
            end else if (fetch) begin
                state_d  = FE_ISSUE;
                fe_start = 1'b1;
                fe_addr  = pc;
`endif
            end
        end
    end

    always_comb begin
        busy_d      = (state_d != IDLE);
        wen_d       = acc_wr;
        waddr_d     = acc_wr ? mar : waddr_q;
        wdata_d     = acc_wr ? mdr_in : wdata_q;
        err_d       = err_req;
        ren_d       = acc_rd;
        raddr_d     = acc_rd ? mar : raddr_q;
        mdr_valid_d = cap_rd;
        mdr_d       = cap_rd ? rdata : mdr_q;
`ifdef MIC1_MEMIF_FETCH_EN
        if (fe_start) begin
            ren_d   = 1'b1;
            raddr_d = fe_addr;
        end
        mbr_valid_d = cap_fe;
        mbr_d       = cap_fe ? rdata : mbr_q;
`endif
    end

    assign busy      = busy_q;
    assign wen       = wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign ren       = ren_q;
    assign raddr     = raddr_q;
    assign err       = err_q;
    assign mdr_out   = mdr_q;
    assign mdr_valid = mdr_valid_q;
`ifdef MIC1_MEMIF_FETCH_EN
    assign mbr_out   = mbr_q;
    assign mbr_valid = mbr_valid_q;
`else
    assign mbr_out   = '0;
    assign mbr_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mic1_mem_if.sv
// Scoreboard bench for mic1_mem_if: lane 0 runs RD_LAT=1, lane 1 runs RD_LAT=3, each with its own memory model.
// Expected output events (edge number + payload) are queued when stimulus is driven and matched by a monitor.
module tb_mic1_mem_if;

`ifdef MIC1_MEMIF_FETCH_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif

    typedef enum int {K_WEN, K_REN, K_ERR, K_MDR, K_MBR} kind_e;
    typedef struct {
        int          lane;
        kind_e       kind;
        int          edge_no;
        logic [8:0]  a;
        logic [8:0]  d;
    } exp_t;

    logic       clk;
    logic       rst       [2];
    logic [8:0] mar       [2];
    logic [8:0] pc        [2];
    logic [8:0] mdr_in    [2];
    logic       rd        [2];
    logic       wr        [2];
    logic       fetch     [2];
    logic       busy      [2];
    logic [8:0] mdr_out   [2];
    logic       mdr_valid [2];
    logic [8:0] mbr_out   [2];
    logic       mbr_valid [2];
    logic       err       [2];
    logic       wen       [2];
    logic [8:0] waddr     [2];
    logic [8:0] wdata     [2];
    logic       ren       [2];
    logic [8:0] raddr     [2];
    logic [8:0] rdata     [2];

    logic [8:0] ref_mem [2][512];
    exp_t       sb_q[$];
    int         edge_cnt;
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    for (genvar g = 0; g < 2; g++) begin : gen_lane
        localparam int L = (g == 0) ? 1 : 3;
        logic [8:0] mem  [512];
        logic [8:0] pipe [L];

        mic1_mem_if #(.ADDR_W(9), .DATA_W(9), .RD_LAT(L)) u_dut (
            .clk(clk), .rst(rst[g]), .mar(mar[g]), .pc(pc[g]), .mdr_in(mdr_in[g]),
            .rd(rd[g]), .wr(wr[g]), .fetch(fetch[g]), .busy(busy[g]),
            .mdr_out(mdr_out[g]), .mdr_valid(mdr_valid[g]),
            .mbr_out(mbr_out[g]), .mbr_valid(mbr_valid[g]), .err(err[g]),
            .wen(wen[g]), .waddr(waddr[g]), .wdata(wdata[g]),
            .ren(ren[g]), .raddr(raddr[g]), .rdata(rdata[g])
        );

        // Memory drives zero when no read was issued, so a mistimed capture sees the wrong word.
        always @(posedge clk) begin
            if (wen[g] === 1'b1) mem[waddr[g]] <= wdata[g];
            pipe[0] <= (ren[g] === 1'b1) ? mem[raddr[g]] : 9'h000;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign rdata[g] = pipe[L-1];
    end

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic void sb_push(input int lane, input kind_e k, input int e,
                                    input logic [8:0] a, input logic [8:0] d);
        exp_t x;
        x.lane = lane; x.kind = k; x.edge_no = e; x.a = a; x.d = d;
        sb_q.push_back(x);
    endfunction

    task automatic observe(input int lane, input kind_e k, input logic [8:0] a, input logic [8:0] d);
        int idx;
        idx = -1;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].lane == lane && sb_q[i].kind == k) begin
                idx = i;
                break;
            end
        end
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL unexpected_%s lane%0d: got event at edge=%0d a=%0h d=%0h, required no event",
                     k.name(), lane, edge_cnt, a, d);
        end else begin
            if (sb_q[idx].edge_no !== edge_cnt || sb_q[idx].a !== a || sb_q[idx].d !== d) begin
                bad++;
                $display("FAIL %s lane%0d: got edge=%0d a=%0h d=%0h, required edge=%0d a=%0h d=%0h",
                         k.name(), lane, edge_cnt, a, d, sb_q[idx].edge_no, sb_q[idx].a, sb_q[idx].d);
            end
            sb_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (wen[l] === 1'b1)       observe(l, K_WEN, waddr[l], wdata[l]);
            if (ren[l] === 1'b1)       observe(l, K_REN, raddr[l], 9'h000);
            if (err[l] === 1'b1)       observe(l, K_ERR, 9'h000, 9'h000);
            if (mdr_valid[l] === 1'b1) observe(l, K_MDR, 9'h000, mdr_out[l]);
            if (mbr_valid[l] === 1'b1) observe(l, K_MBR, 9'h000, mbr_out[l]);
        end
    end

    task automatic wait_edge(input int e);
        int guard;
        guard = 0;
        while (edge_cnt < e && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_cnt < e) begin
            total++;
            bad++;
            $display("FAIL wait_timeout: got edge=%0d, required edge=%0d", edge_cnt, e);
        end
    endtask

    task automatic finish_test(input string name, input int last_edge);
        wait_edge(last_edge + 1);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: got %0d unseen events (first lane%0d %s edge=%0d), required 0",
                     name, sb_q.size(), sb_q[0].lane, sb_q[0].kind.name(), sb_q[0].edge_no);
            sb_q.delete();
        end
    endtask

    // Called just after a negedge; the request is accepted at the next edge.
    task automatic req(input int g, input bit w, input bit r, input bit f, input logic [8:0] a,
                       input logic [8:0] p, input logic [8:0] d, output int t_done);
        int t;
        int c;
        bit fe;
        fe = f && FE_ON;
        mar[g] = a; pc[g] = p; mdr_in[g] = d;
        wr[g] = w; rd[g] = r; fetch[g] = f;
        t = edge_cnt + 1;
        t_done = t;
        if (w) begin
            sb_push(g, K_WEN, t, a, d);
            ref_mem[g][a] = d;
            if (r) sb_push(g, K_ERR, t, 9'h000, 9'h000);
            t_done = t + 1;
            if (fe) begin
                sb_push(g, K_REN, t + 1, p, 9'h000);
                sb_push(g, K_MBR, t + 2 + lat(g), 9'h000, ref_mem[g][p]);
                t_done = t + 2 + lat(g);
            end
        end else if (r) begin
            c = t + 1 + lat(g);
            sb_push(g, K_REN, t, a, 9'h000);
            sb_push(g, K_MDR, c, 9'h000, ref_mem[g][a]);
            t_done = c;
            if (fe) begin
                sb_push(g, K_REN, c, p, 9'h000);
                sb_push(g, K_MBR, c + 1 + lat(g), 9'h000, ref_mem[g][p]);
                t_done = c + 1 + lat(g);
            end
        end else if (fe) begin
            sb_push(g, K_REN, t, p, 9'h000);
            sb_push(g, K_MBR, t + 1 + lat(g), 9'h000, ref_mem[g][p]);
            t_done = t + 1 + lat(g);
        end
        @(negedge clk);
        wr[g] = 1'b0; rd[g] = 1'b0; fetch[g] = 1'b0;
    endtask

    function automatic logic [50:0] outs_vec(input int g);
        return {busy[g], wen[g], ren[g], err[g], mdr_valid[g], mbr_valid[g],
                waddr[g], wdata[g], raddr[g], mdr_out[g], mbr_out[g]};
    endfunction

    task automatic test_reset();
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; rd[g] = 1'b0; wr[g] = 1'b0; fetch[g] = 1'b0;
            mar[g] = '0; pc[g] = '0; mdr_in[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            total++;
            if (outs_vec(g) !== 51'd0) begin
                bad++;
                $display("FAIL reset_values lane%0d: got %h, required 0", g, outs_vec(g));
            end
            rst[g] = 1'b0;
        end
    endtask

    task automatic test_write_read();
        int d1, d2;
        req(0, 1'b1, 1'b0, 1'b0, 9'd10, 9'd0, 9'd99, d1);
        total++;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b, required 1", busy[0]); end
        req(0, 1'b0, 1'b1, 1'b0, 9'd10, 9'd0, 9'd0, d2);
        total++;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL rd_busy: got %b, required 1", busy[0]); end
        wait_edge(d2);
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL rd_busy_drop: got %b, required 0", busy[0]); end
        finish_test("write_read", d2);
    endtask

    task automatic test_illegal();
        int d;
        req(0, 1'b1, 1'b1, 1'b0, 9'd5, 9'd0, 9'h0FF, d);
        total++;
        if (err[0] !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b, required 1", err[0]); end
        finish_test("illegal_wr_rd", d + 4);
        req(0, 1'b0, 1'b1, 1'b0, 9'd5, 9'd0, 9'd0, d);
        finish_test("illegal_readback", d);
        req(0, 1'b1, 1'b1, 1'b1, 9'd6, 9'd6, 9'h0AB, d);
        finish_test("illegal_wr_rd_fetch", d + 3);
    endtask

    task automatic test_wr_fetch();
        int d;
        req(0, 1'b1, 1'b0, 1'b1, 9'd9, 9'd9, 9'h123, d);
        @(negedge clk);
        total++;
        if (busy[0] !== FE_ON) begin
            bad++;
            $display("FAIL wr_fetch_busy: got %b, required %b", busy[0], FE_ON);
        end
        finish_test("wr_fetch", d);
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        req(0, 1'b0, 1'b1, 1'b0, 9'd10, 9'd0, 9'd0, d1);
        wait_edge(d1 - 1);
        req(0, 1'b0, 1'b1, 1'b0, 9'd5, 9'd0, 9'd0, d2);
        total++;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b, required 1", busy[0]); end
        finish_test("back_to_back", d2);
    endtask

    task automatic test_busy_ignore();
        int d1, d2;
        req(1, 1'b1, 1'b0, 1'b0, 9'd12, 9'd0, 9'h155, d1);
        wait_edge(d1 - 1);
        req(1, 1'b0, 1'b1, 1'b0, 9'd12, 9'd0, 9'd0, d2);
        wr[1] = 1'b1; mar[1] = 9'd20; mdr_in[1] = 9'h077;
        @(negedge clk);
        @(negedge clk);
        wr[1] = 1'b0;
        total++;
        if (busy[1] !== 1'b1) begin bad++; $display("FAIL busy_hold: got %b, required 1", busy[1]); end
        finish_test("busy_ignore", d2);
    endtask

    task automatic test_reset_mid_read();
        int t, d;
        mar[1] = 9'd12; rd[1] = 1'b1;
        t = edge_cnt + 1;
        sb_push(1, K_REN, t, 9'd12, 9'h000);
        @(negedge clk);
        rd[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        total++;
        if (outs_vec(1) !== 51'd0) begin
            bad++;
            $display("FAIL mid_read_reset: got %h, required 0", outs_vec(1));
        end
        rst[1] = 1'b0;
        finish_test("mid_read_no_capture", t + 8);
        req(1, 1'b0, 1'b1, 1'b0, 9'd12, 9'd0, 9'd0, d);
        finish_test("after_reset_read", d);
    endtask

`ifdef MIC1_MEMIF_FETCH_EN
    task automatic test_rd_fetch();
        int d;
        req(0, 1'b1, 1'b0, 1'b0, 9'd3, 9'd0, 9'h1A5, d);
        req(0, 1'b1, 1'b0, 1'b0, 9'd7, 9'd0, 9'h042, d);
        req(0, 1'b0, 1'b1, 1'b1, 9'd3, 9'd7, 9'd0, d);
        while (edge_cnt < d) begin
            total++;
            if (busy[0] !== 1'b1) begin
                bad++;
                $display("FAIL rd_fetch_busy edge=%0d: got %b, required 1", edge_cnt, busy[0]);
            end
            @(negedge clk);
        end
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL rd_fetch_release: got %b, required 0", busy[0]); end
        finish_test("rd_fetch", d);
    endtask
`else
    task automatic test_no_fetch();
        int d;
        req(0, 1'b0, 1'b0, 1'b1, 9'd0, 9'd7, 9'd0, d);
        repeat (4) begin
            total++;
            if ({busy[0], ren[0], mbr_valid[0], mbr_out[0]} !== 12'd0) begin
                bad++;
                $display("FAIL no_fetch_idle edge=%0d: got busy=%b ren=%b mbr_valid=%b mbr=%h, required all 0",
                         edge_cnt, busy[0], ren[0], mbr_valid[0], mbr_out[0]);
            end
            @(negedge clk);
        end
        req(0, 1'b0, 1'b1, 1'b1, 9'd10, 9'd7, 9'd0, d);
        finish_test("no_fetch_rd", d);
        total++;
        if (mbr_out[0] !== 9'd0) begin bad++; $display("FAIL no_fetch_mbr: got %h, required 0", mbr_out[0]); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_illegal();
        test_wr_fetch();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_read();
`ifdef MIC1_MEMIF_FETCH_EN
        test_rd_fetch();
`else
        test_no_fetch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mic1_mem_if.md
# mic1_mem_if

Initiator-side memory interface for the MIC-1 datapath. It drives the main memory write and read ports (`wen`/`waddr`/`wdata`, `ren`/`raddr`/`rdata`) and turns the datapath's `rd`, `wr` and `fetch` strobes into correctly timed memory transactions. Returned words are captured into MDR (data reads) or MBR (instruction fetch). A `busy` handshake protects the datapath from issuing overlapping requests.

## Interface
- `ADDR_W`, 9: address width; matches main memory.
- `DATA_W`, 9: data width; matches main memory.
- `RD_LAT`, 1: main memory read latency in cycles. Legal range 1..4.
- `clk` in 1: single clock; all logic rises on the positive edge.
- `rst` in 1: synchronous, active-high reset.
- `mar` in ADDR_W: data address for `rd`/`wr`.
- `pc` in ADDR_W: fetch address.
- `mdr_in` in DATA_W: write data for `wr`.
- `rd` in 1: data read request; sampled only when `busy`=0.
- `wr` in 1: write request; sampled only when `busy`=0.
- `fetch` in 1: instruction fetch request; sampled only when `busy`=0.
- `busy` out 1: transaction in progress; requests are ignored while high.
- `mdr_out` out DATA_W: last word captured by `rd`.
- `mdr_valid` out 1: one-cycle pulse when `mdr_out` updates.
- `mbr_out` out DATA_W: last word captured by `fetch`.
- `mbr_valid` out 1: one-cycle pulse when `mbr_out` updates.
- `err` out 1: one-cycle pulse on an illegal request combination.
- `wen` out 1: memory write enable.
- `waddr` out ADDR_W: memory write address.
- `wdata` out DATA_W: memory write data.
- `ren` out 1: memory read enable.
- `raddr` out ADDR_W: memory read address.
- `rdata` in DATA_W: memory read data; valid `RD_LAT` edges after the edge at which memory samples `ren`.

## Operation
- **FSM states:** IDLE, WRITE, RD_ISSUE, RD_WAIT, FE_ISSUE, FE_WAIT.
- **Registered outputs:** every output is registered. Reset values: `busy`=0, `wen`=0, `ren`=0, `err`=0, `mdr_valid`=0, `mbr_valid`=0, all address/data outputs 0, `mdr_out`=0, `mbr_out`=0.
- **IDLE + `wr`:** go to WRITE. Register `waddr`=`mar`, `wdata`=`mdr_in`, `wen`=1 for exactly one cycle, then return to IDLE.
- **IDLE + `rd`:** go to RD_ISSUE. Set `raddr`=`mar` and `ren`=1 for one cycle. In RD_WAIT, a down-counter runs `RD_LAT` edges, then `rdata` is captured into `mdr_out` and `mdr_valid` pulses.
- **IDLE + `fetch`:** same sequence as `rd`, using FE_ISSUE/FE_WAIT with `raddr`=`pc`, capturing into `mbr_out` and pulsing `mbr_valid`.
- **`rd` and `fetch` together:** both are accepted. The read is served first; `pc` is latched at acceptance and a pending-fetch flag is set. When the read completes, the FSM goes straight to FE_ISSUE and `busy` stays high throughout.
- **`wr` and `rd` together:** illegal. The write is performed, the read is dropped, and `err` pulses. If `fetch` is also present it is queued behind the write.
- **`wr` and `fetch` together:** legal. Write first, then fetch, with no idle gap.
- **Address wrap:** addresses are used as given; there is no wrap or bounds logic.
- **Reset mid-transaction:** `rst` wins over every transition. The FSM returns to IDLE, the pending fetch is dropped, and any in-flight `rdata` is never captured.

## Timing
- A request is accepted at edge T when `busy`=0.
  - `busy` goes high after T.
  - `wen`/`ren` go high after T; memory samples them at T+1.
- **Write:** `busy` is high for 1 cycle. A new request is accepted at T+1.
- **Read or fetch:** capture happens at edge T+1+`RD_LAT`.
  - `mdr_valid`/`mbr_valid` are high in the following cycle.
  - `busy` falls at that same edge, so a back-to-back request is accepted at T+1+`RD_LAT`.
- **Queued rd+fetch:** fetch `ren` rises after the read's capture edge. MBR is captured `RD_LAT`+1 edges later.
- **Combinational paths:** none from inputs to outputs.

## Configuration
- **`MIC1_MEMIF_FETCH_EN` defined:** the fetch path, MBR, FE_* states and the pending-fetch queue are built.
- **`MIC1_MEMIF_FETCH_EN` undefined:**
  - `fetch` and `pc` are ignored.
  - `mbr_out`=0 and `mbr_valid`=0 permanently.
  - FE_* states are absent.
  - `rd` and `wr` behaviour and timing are unchanged.

## Test plan
- **Write then read back:** `RD_LAT`=1; `wr` with `mar`=10, `mdr_in`=99; then `rd` with `mar`=10.
  - Expect `wen` high for exactly 1 cycle with `waddr`=10, `wdata`=99.
  - Expect `mdr_out`=99 and `mdr_valid` pulsing 2 edges after `rd` is accepted.
- **Simultaneous read and fetch:** preload mem[3]=0x1A5 and mem[7]=0x042; `rd`(`mar`=3) and `fetch`(`pc`=7) in the same cycle.
  - Expect `mdr_out`=0x1A5 first, then `mbr_out`=0x042.
  - Expect `busy` held high continuously across both transactions.
- **Illegal wr+rd:** `wr`(`mar`=5, `mdr_in`=0x0FF) together with `rd`.
  - Expect mem[5]=0x0FF, one `err` pulse, and no `mdr_valid`.
- **Requests while busy:** `RD_LAT`=3; issue `rd`, then pulse `wr` while `busy`=1.
  - Expect the `wr` ignored: no `wen`.
  - Expect `mdr_valid` 4 edges after acceptance.
- **Reset mid-read:** assert `rst` during RD_WAIT.
  - Expect all outputs at their reset values on the next cycle.
  - Expect no `mdr_valid` afterwards, and a new `rd` accepted normally.
- **Build without fetch:** compile without `MIC1_MEMIF_FETCH_EN`; issue `fetch`(`pc`=7).
  - Expect `busy` to stay 0, `ren` to stay 0, and `mbr_out`=0.
